cr_kme_ctr_drbg_gen: RTL and testbench
======================================

Name: cr_kme_ctr_drbg_gen

Overview:
Parametrised CTR-mode AES-256 deterministic random number generator for the KME.
- Seeded with a 384-bit seed (256-bit key, 128-bit counter V).
- Emits BLK_PER_GEN 128-bit random blocks per generate cycle into an internal output FIFO.
- Refreshes key and V after every generate and expires after a programmable number of generates.
- Drives an external, in-order, arbitrary-latency AES-256 encrypt engine over a key/cipher handshake, so the engine can be swapped without touching this block.

Parameters:
BLK_PER_GEN, 2, output blocks per generate cycle (1..8).
FIFO_DEPTH, 6, output FIFO entries; must be >= BLK_PER_GEN.
LIFE_W, 48, width of seed_life and the generate counter.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  load seed and begin; honoured only in EXPIRED
seed  in  384  [383:128] key, [127:0] V
seed_life  in  LIFE_W  generates allowed per seed; sampled on start
zeroize  in  1  clear state, flush FIFO
key_out  out  256  key to engine
key_vld  out  1  key valid
key_stall  in  1  engine cannot accept key
ciph_in  out  128  plaintext counter block
ciph_in_vld  out  1  block valid
ciph_in_last  out  1  final block of generate
ciph_in_stall  in  1  engine cannot accept block
ciph_out  in  128  ciphertext
ciph_out_vld  in  1  ciphertext valid; no backpressure
drng_out  out  128  FIFO head
drng_valid  out  1  FIFO non-empty
drng_ack  in  1  pop FIFO head
seed_expired  out  1  state == EXPIRED
drng_idle  out  1  EXPIRED or WAIT_SPACE
fifo_overflow  out  1  one-cycle pulse: push while full
fifo_underflow  out  1  one-cycle pulse: ack while empty
health_fail  out  1  sticky health error (see Optional Feature)

Behaviour:
Reset:
- State EXPIRED; key, V, gen_cnt, life, in/out counters all 0; FIFO empty.
- Outputs 0 except seed_expired=1 and drng_idle=1.

States:
- EXPIRED:
  - key <= seed[383:128], V <= seed[127:0], gen_cnt <= 0 every cycle.
  - On start: life <= seed_life; go to LOAD_KEY.
- LOAD_KEY:
  - key_vld=1, key_out=key.
  - Accepted when !key_stall; then go to WAIT_SPACE.
- WAIT_SPACE:
  - Go to SEND when FIFO free entries >= BLK_PER_GEN.
  - Result: no push can overflow.
- SEND:
  - Issue M = BLK_PER_GEN+3 blocks, one per cycle while !ciph_in_stall.
  - Block i (i=1..M) = V+i mod 2^128.
  - ciph_in_last=1 on block M; on its acceptance go to COLLECT.
  - Outputs must not change while stalled.
- COLLECT:
  - Out counter j counts ciph_out_vld during SEND and COLLECT; ciphertext may arrive while SEND is still issuing.
  - Routing of ciphertext j:
    - j <= BLK_PER_GEN: pushed to FIFO.
    - j = N+1: key[255:128].
    - j = N+2: key[127:0].
    - j = N+3: V.
  - On j=M: gen_cnt++; if new gen_cnt >= life (life=0 acts as 1), go to EXPIRED; else go to LOAD_KEY.
- DRAIN: see zeroize below.

zeroize (any state, priority over start):
- key, V, gen_cnt cleared; FIFO flushed same cycle.
- If outstanding (issued minus returned) > 0: go to DRAIN, discard ciph_out until outstanding = 0, then go to EXPIRED.
- Otherwise go directly to EXPIRED.
- A key accepted in the same cycle is ignored.

FIFO:
- Simultaneous push and pop when full or empty is legal.
- Pop on empty is ignored and pulses fifo_underflow.
- drng_out = 0 when empty.

Optional Feature:
Macro: CR_KME_DRNG_HEALTH_EN.
With the macro:
- Each FIFO-bound block is compared to the previous one; the previous-block register is cleared on zeroize and on start.
- On equality:
  - Block is dropped, not pushed.
  - health_fail sets.
  - Current generate completes, then state goes to EXPIRED.
- start is ignored while health_fail=1; only zeroize clears it.
Without the macro: health_fail tied 0, no comparator.

Test Plan:
1. Identity engine (out=in, latency 3); BLK_PER_GEN=2, V=0x10, life=2, start:
   - drng_out sequence 0x11, 0x12, 0x16, 0x17.
   - Second key_out = {0x13, 0x14}.
   - seed_expired=1 after 2nd generate.
2. Depth 6, life=10, no ack:
   - Three generates fill the FIFO.
   - 4th generate holds in WAIT_SPACE: drng_idle=1, ciph_in_vld=0.
   - Two acks: resumes, FIFO returns to 6.
3. V=2^128-2 -> first outputs 0xFFFF…FF, then 0x0 (wrap).
4. key_stall held 5 cycles, ciph_in_stall random 50%:
   - Exactly 5 distinct blocks issued per generate.
   - No skip or duplicate; ciph_in_last only on block 5.
5. zeroize mid-SEND with 3 outstanding:
   - 3 returns discarded; FIFO empty.
   - seed_expired=1 after last return.
   - Restart with same seed reproduces 0x11, 0x12.
6. Ack while empty -> fifo_underflow one-cycle pulse. With HEALTH_EN, constant-output engine -> health_fail=1, second block dropped, start ignored until zeroize.

Source files
------------

// File: rtl/cr_kme_ctr_drbg_gen.sv
// rtl/cr_kme_ctr_drbg_gen.sv - CTR-mode AES-256 DRBG block generator with output FIFO
// Optional repeated-block health check: define CR_KME_DRNG_HEALTH_EN.
module cr_kme_ctr_drbg_gen #(
    parameter int BLK_PER_GEN = 2,
    parameter int FIFO_DEPTH  = 6,
    parameter int LIFE_W      = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [383:0]      seed,
    input  logic [LIFE_W-1:0] seed_life,
    input  logic              zeroize,
    output logic [255:0]      key_out,
    output logic              key_vld,
    input  logic              key_stall,
    output logic [127:0]      ciph_in,
    output logic              ciph_in_vld,
    output logic              ciph_in_last,
    input  logic              ciph_in_stall,
    input  logic [127:0]      ciph_out,
    input  logic              ciph_out_vld,
    output logic [127:0]      drng_out,
    output logic              drng_valid,
    input  logic              drng_ack,
    output logic              seed_expired,
    output logic              drng_idle,
    output logic              fifo_overflow,
    output logic              fifo_underflow,
    output logic              health_fail
);
    localparam int CNT_W  = 4;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] N_C = CNT_W'(BLK_PER_GEN);
    localparam logic [CNT_W-1:0] M_C = CNT_W'(BLK_PER_GEN + 3);

    typedef enum logic [2:0] {EXPIRED, LOAD_KEY, WAIT_SPACE, SEND, COLLECT, DRAIN} state_t;

    state_t            state_q;
    logic [255:0]      key_q;
    logic [127:0]      v_q;
    logic [LIFE_W-1:0] gen_cnt_q, life_q;
    logic [CNT_W-1:0]  in_cnt_q, out_cnt_q;
    logic [127:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic              ovf_q, unf_q;

    logic              issue, ret, collecting, blk_hit, gen_done, expire;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop, push_ok, space_ok;
    logic [CNT_W-1:0]  j_cur;
    logic [CNT_W:0]    outstanding_d;
    logic [LIFE_W-1:0] gen_cnt_d, life_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign issue      = (state_q == SEND) && !ciph_in_stall;
    assign ret        = ciph_out_vld && (state_q inside {SEND, COLLECT, DRAIN});
    assign collecting = ciph_out_vld && (state_q inside {SEND, COLLECT});
    assign j_cur      = out_cnt_q + CNT_W'(1);
    assign gen_done   = collecting && (j_cur == M_C);

    // a life of zero still allows one generate
    assign life_eff  = (life_q == '0) ? LIFE_W'(1) : life_q;
    assign gen_cnt_d = gen_cnt_q + LIFE_W'(1);
    assign expire    = gen_cnt_d >= life_eff;

    // blocks still inside the engine once this cycle's handshakes complete
    assign outstanding_d = {1'b0, in_cnt_q} + (CNT_W+1)'(issue)
                         - {1'b0, out_cnt_q} - (CNT_W+1)'(ret);

    assign fifo_full  = fcnt_q == FCNT_W'(FIFO_DEPTH);
    assign fifo_empty = fcnt_q == '0;
    assign fifo_push  = collecting && (j_cur <= N_C) && !blk_hit && !zeroize;
    assign fifo_pop   = drng_ack && !fifo_empty && !zeroize;
    assign push_ok    = fifo_push && (!fifo_full || fifo_pop);
    assign space_ok   = ((FCNT_W+1)'(fcnt_q) + (FCNT_W+1)'(BLK_PER_GEN)) <= (FCNT_W+1)'(FIFO_DEPTH);

    assign key_vld        = state_q == LOAD_KEY;
    assign key_out        = key_vld ? key_q : '0;
    assign ciph_in_vld    = state_q == SEND;
    assign ciph_in        = ciph_in_vld ? (v_q + 128'(in_cnt_q) + 128'd1) : '0;
    assign ciph_in_last   = ciph_in_vld && (in_cnt_q == M_C - CNT_W'(1));
    assign drng_valid     = !fifo_empty;
    assign drng_out       = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign seed_expired   = state_q == EXPIRED;
    assign drng_idle      = (state_q == EXPIRED) || (state_q == WAIT_SPACE);
    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = unf_q;

`ifdef CR_KME_DRNG_HEALTH_EN
    logic [127:0] prev_q;
    logic         prev_vld_q;
    logic         health_q;

    assign blk_hit     = collecting && (j_cur <= N_C) && prev_vld_q && (ciph_out == prev_q);
    assign health_fail = health_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            health_q   <= 1'b0;
        end else if (zeroize) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            health_q   <= 1'b0;
        end else if (state_q == EXPIRED && start && !health_q) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (collecting && (j_cur <= N_C)) begin
            if (blk_hit) begin
                health_q <= 1'b1;
            end else begin
                prev_q     <= ciph_out;
                prev_vld_q <= 1'b1;
            end
        end
    end
`else
    assign blk_hit     = 1'b0;
    assign health_fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= ciph_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            ovf_q <= fifo_push && fifo_full && !fifo_pop;
            unf_q <= drng_ack && fifo_empty;
            if (zeroize) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                fcnt_q   <= '0;
            end else begin
                if (push_ok)  wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
                fcnt_q <= fcnt_q + FCNT_W'(push_ok) - FCNT_W'(fifo_pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EXPIRED;
            key_q     <= '0;
            v_q       <= '0;
            gen_cnt_q <= '0;
            life_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else if (zeroize) begin
            key_q     <= '0;
            v_q       <= '0;
            gen_cnt_q <= '0;
            if (outstanding_d != '0) begin
                state_q   <= DRAIN;
                in_cnt_q  <= in_cnt_q + CNT_W'(issue);
                out_cnt_q <= out_cnt_q + CNT_W'(ret);
            end else begin
                state_q   <= EXPIRED;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end
        end else begin
            case (state_q)
                EXPIRED: begin
                    key_q     <= seed[383:128];
                    v_q       <= seed[127:0];
                    gen_cnt_q <= '0;
                    if (start && !health_fail) begin
                        life_q  <= seed_life;
                        state_q <= LOAD_KEY;
                    end
                end
                LOAD_KEY: begin
                    if (!key_stall) state_q <= WAIT_SPACE;
                end
                WAIT_SPACE: begin
                    if (space_ok) state_q <= SEND;
                end
                SEND, COLLECT: begin
                    if (issue) begin
                        in_cnt_q <= in_cnt_q + CNT_W'(1);
                        if (in_cnt_q == M_C - CNT_W'(1)) state_q <= COLLECT;
                    end
                    // ciphertexts past the FIFO blocks become the next key and V
                    if (collecting) begin
                        out_cnt_q <= j_cur;
                        if (j_cur == N_C + CNT_W'(1)) key_q[255:128] <= ciph_out;
                        if (j_cur == N_C + CNT_W'(2)) key_q[127:0]   <= ciph_out;
                        if (j_cur == M_C)             v_q            <= ciph_out;
                    end
                    if (gen_done) begin
                        gen_cnt_q <= gen_cnt_d;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        state_q   <= (expire || health_fail) ? EXPIRED : LOAD_KEY;
                    end
                end
                DRAIN: begin
                    if (ret) out_cnt_q <= out_cnt_q + CNT_W'(1);
                    if (outstanding_d == '0) begin
                        state_q   <= EXPIRED;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                    end
                end
                default: state_q <= EXPIRED;
            endcase
        end
    end
endmodule

// File: tb/tb_cr_kme_ctr_drbg_gen.sv
// tb/tb_cr_kme_ctr_drbg_gen.sv - scoreboard bench for cr_kme_ctr_drbg_gen with a latency-3 engine model
`timescale 1ns/1ps
module tb_cr_kme_ctr_drbg_gen;
    localparam int N = 2, DEPTH = 6, LW = 48, M = N + 3, LAT = 3;
    localparam logic [255:0] KEY0      = 256'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f_1011_1213_1415_1617_1819_1a1b_1c1d_1e1f;
    localparam logic [127:0] CONST_BLK = 128'hC0FFEE;

    logic           clk, rst_n, start, zeroize;
    logic [383:0]   seed;
    logic [LW-1:0]  seed_life;
    logic [255:0]   key_out;
    logic           key_vld, key_stall;
    logic [127:0]   ciph_in, ciph_out, drng_out;
    logic           ciph_in_vld, ciph_in_last, ciph_in_stall, ciph_out_vld;
    logic           drng_valid, drng_ack, seed_expired, drng_idle;
    logic           fifo_overflow, fifo_underflow, health_fail;

    cr_kme_ctr_drbg_gen #(.BLK_PER_GEN(N), .FIFO_DEPTH(DEPTH), .LIFE_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .seed_life(seed_life),
        .zeroize(zeroize), .key_out(key_out), .key_vld(key_vld), .key_stall(key_stall),
        .ciph_in(ciph_in), .ciph_in_vld(ciph_in_vld), .ciph_in_last(ciph_in_last),
        .ciph_in_stall(ciph_in_stall), .ciph_out(ciph_out), .ciph_out_vld(ciph_out_vld),
        .drng_out(drng_out), .drng_valid(drng_valid), .drng_ack(drng_ack),
        .seed_expired(seed_expired), .drng_idle(drng_idle), .fifo_overflow(fifo_overflow),
        .fifo_underflow(fifo_underflow), .health_fail(health_fail)
    );

    int           checks = 0, errors = 0;
    logic [127:0] exp_q[$];
    logic [255:0] keys[$];
    logic         auto_ack = 0, force_ack = 0, stall_rand = 0, const_mode = 0, chk_blk = 1;
    logic         ovf_seen = 0;
    int           ack_budget = 0, pops = 0, gens = 0, ret_total = 0;
    logic [127:0] exp_blk = '0;
    int           blk_idx = 1;
    logic [127:0] pd[LAT];
    logic         pv[LAT];

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [255:0] k, input logic [127:0] v, input int life);
        seed      = {k, v};
        seed_life = LW'(life);
        exp_blk   = v + 128'd1;
        blk_idx   = 1;
        keys.delete();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic push_gen(input logic [127:0] v, input int life);
        logic [127:0] b;
        for (int g = 0; g < life; g++)
            for (int i = 1; i <= N; i++) begin
                b = v + 128'(g * M + i);
                exp_q.push_back(b);
            end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(seed_expired && exp_q.size() == 0) && n < 3000) begin
            tick();
            n++;
        end
        chk(name, 256'(seed_expired && exp_q.size() == 0), 256'd1);
    endtask

    // engine model: identity (or constant) cipher with fixed latency
    initial begin
        ciph_out = '0; ciph_out_vld = 0; ciph_in_stall = 0;
        for (int k = 0; k < LAT; k++) begin pv[k] = 0; pd[k] = '0; end
        forever begin
            @(negedge clk);
            ciph_out_vld = pv[LAT-1];
            ciph_out     = pv[LAT-1] ? pd[LAT-1] : '0;
            if (pv[LAT-1]) ret_total++;
            for (int k = LAT - 1; k > 0; k--) begin pv[k] = pv[k-1]; pd[k] = pd[k-1]; end
            ciph_in_stall = stall_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            pv[0] = rst_n && ciph_in_vld && !ciph_in_stall;
            pd[0] = const_mode ? CONST_BLK : ciph_in;
            if (pv[0]) begin
                if (chk_blk) begin
                    chk("ciph_in", 256'(ciph_in), 256'(exp_blk));
                    chk("ciph_in_last", 256'(ciph_in_last), 256'(blk_idx == M));
                end
                if (ciph_in_last) gens++;
                exp_blk = exp_blk + 128'd1;
                blk_idx = (blk_idx == M) ? 1 : blk_idx + 1;
            end
            if (rst_n && key_vld && !key_stall) keys.push_back(key_out);
        end
    end

    // scoreboard monitor: pops and compares the FIFO head whenever it acks
    initial begin
        logic [127:0] e;
        drng_ack = 0;
        forever begin
            @(negedge clk);
            ovf_seen = ovf_seen | fifo_overflow;
            if (drng_valid && (auto_ack || ack_budget > 0)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL drng_out: got %h expected nothing", drng_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("drng_out", 256'(drng_out), 256'(e));
                end
                pops++;
                if (!auto_ack) ack_budget--;
                drng_ack = 1;
            end else begin
                drng_ack = force_ack;
            end
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int g0, p0, zret, n;
        rst_n = 0; start = 0; seed = '0; seed_life = '0; zeroize = 0; key_stall = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        tick();
        chk("rst_seed_expired", 256'(seed_expired), 256'd1);
        chk("rst_drng_idle", 256'(drng_idle), 256'd1);
        chk("rst_key_vld", 256'(key_vld), 256'd0);
        chk("rst_key_out", key_out, 256'd0);
        chk("rst_ciph_in_vld", 256'(ciph_in_vld), 256'd0);
        chk("rst_drng_valid", 256'(drng_valid), 256'd0);
        chk("rst_drng_out", 256'(drng_out), 256'd0);
        chk("rst_flags", 256'({fifo_overflow, fifo_underflow, health_fail}), 256'd0);

        // identity engine, two generates
        auto_ack = 1;
        exp_q.push_back(128'h11); exp_q.push_back(128'h12);
        exp_q.push_back(128'h16); exp_q.push_back(128'h17);
        do_start(KEY0, 128'h10, 2);
        wait_done("t1_done");
        chk("t1_key_count", 256'(keys.size()), 256'd2);
        chk("t1_key0", keys[0], KEY0);
        chk("t1_key1", keys[1], {128'h13, 128'h14});

        // fill FIFO without acks, then release two entries
        auto_ack = 0;
        g0 = gens; p0 = pops;
        push_gen(128'h100, 10);
        do_start(KEY0, 128'h100, 10);
        repeat (80) tick();
        chk("t2_idle", 256'(drng_idle), 256'd1);
        chk("t2_no_issue", 256'(ciph_in_vld), 256'd0);
        chk("t2_not_expired", 256'(seed_expired), 256'd0);
        chk("t2_gens3", 256'(gens - g0), 256'd3);
        ack_budget = 2;
        repeat (40) tick();
        chk("t2_pops2", 256'(pops - p0), 256'd2);
        chk("t2_gens4", 256'(gens - g0), 256'd4);
        chk("t2_idle_again", 256'(drng_idle && !ciph_in_vld && !seed_expired), 256'd1);
        auto_ack = 1;
        wait_done("t2_done");
        chk("t2_pops20", 256'(pops - p0), 256'd20);
        chk("t2_gens10", 256'(gens - g0), 256'd10);

        // counter wrap
        exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
        exp_q.push_back(128'h0);
        do_start(KEY0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1);
        wait_done("t3_done");

        // key stall then random block stall
        key_stall = 1;
        g0 = gens;
        push_gen(128'hABCD_0000, 3);
        do_start(KEY0, 128'hABCD_0000, 3);
        repeat (5) tick();
        chk("t4_key_held", 256'(key_vld), 256'd1);
        chk("t4_no_issue", 256'(ciph_in_vld), 256'd0);
        key_stall = 0;
        stall_rand = 1;
        wait_done("t4_done");
        stall_rand = 0;
        chk("t4_gens3", 256'(gens - g0), 256'd3);

        // zeroize with three blocks in flight
        do_start(KEY0, 128'h10, 1);
        n = 0;
        while (!ciph_in_vld && n < 100) begin tick(); n++; end
        chk("t5_send_seen", 256'(ciph_in_vld), 256'd1);
        tick();
        tick();
        zeroize = 1;
        zret = ret_total;
        tick();
        zeroize = 0;
        chk("t5_draining", 256'(seed_expired), 256'd0);
        chk("t5_fifo_empty", 256'(drng_valid), 256'd0);
        n = 0;
        while (!seed_expired && n < 100) begin tick(); n++; end
        chk("t5_expired", 256'(seed_expired), 256'd1);
        chk("t5_returns", 256'(ret_total - zret), 256'd3);
        chk("t5_fifo_still_empty", 256'(drng_valid), 256'd0);
        exp_q.push_back(128'h11); exp_q.push_back(128'h12);
        do_start(KEY0, 128'h10, 1);
        wait_done("t5_restart");

        // ack on empty FIFO
        chk("t6_empty", 256'(drng_valid), 256'd0);
        force_ack = 1;
        tick();
        force_ack = 0;
        chk("t6_underflow_pulse", 256'(fifo_underflow), 256'd1);
        tick();
        chk("t6_underflow_clear", 256'(fifo_underflow), 256'd0);

`ifdef CR_KME_DRNG_HEALTH_EN
        chk_blk = 0;
        const_mode = 1;
        exp_q.push_back(CONST_BLK);
        do_start(KEY0, 128'h500, 3);
        wait_done("h_done");
        chk("h_fail_set", 256'(health_fail), 256'd1);
        do_start(KEY0, 128'h500, 3);
        repeat (4) tick();
        chk("h_start_ignored", 256'(seed_expired && !key_vld), 256'd1);
        zeroize = 1;
        tick();
        zeroize = 0;
        chk("h_fail_cleared", 256'(health_fail), 256'd0);
        const_mode = 0;
        chk_blk = 1;
`endif

        repeat (5) tick();
        chk("no_overflow", 256'(ovf_seen), 256'd0);
        chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
